// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (output start, a, b, input busy, done, diff, borrow, zero);
    modport slave  (input start, a, b, output busy, done, diff, borrow, zero);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first, one bit per clock.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    serial_subtractor_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, res_q, res_next;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_ff;
    logic             load, shift, last;
    logic             d, bout;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, zero_q, busy_q, done_q;

    full_subtractor u_fs (
        .x    (op_a_q[0]),
        .y    (op_b_q[0]),
        .bin  (borrow_ff),
        .d    (d),
        .bout (bout)
    );

    assign res_next = {d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers are loaded from the final cell output on the last shift
    // edge, so they are already valid during the cycle done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            borrow_ff <= 1'b0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (load) begin
                op_a_q    <= bus.a;
                op_b_q    <= bus.b;
                res_q     <= '0;
                cnt_q     <= '0;
                borrow_ff <= 1'b0;
            end
            if (shift) begin
                op_a_q    <= op_a_q >> 1;
                op_b_q    <= op_b_q >> 1;
                res_q     <= res_next;
                borrow_ff <= bout;
                cnt_q     <= cnt_q + 1'b1;
            end
            if (last) begin
                diff_q   <= res_next;
                borrow_q <= bout;
                zero_q   <= (res_next == '0);
            end
            busy_q <= (state_d == SHIFT);
            done_q <= (state_d == DONE);
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH 8 and 16.
module tb_serial_subtractor;
    import serial_arith_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  bus8  ();
    serial_subtractor_if #(.WIDTH(16)) bus16 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] e_diff,
                       input logic e_bor, input logic e_zero, input string tag);
        int n = 0;
        int busy_n = 0;
        bit got = 0;
        bit overlap = 0;
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.a = ~a; bus8.b = a;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus8.busy && bus8.done) overlap = 1;
            if (bus8.done) got = 1;
            else if (bus8.busy) busy_n++;
        end
        chk({tag, " latency"}, n, 9);
        chk({tag, " busy_cycles"}, busy_n, 8);
        chk({tag, " busy_done_overlap"}, overlap, 0);
        chk({tag, " diff"}, bus8.diff, e_diff);
        chk({tag, " borrow"}, bus8.borrow, e_bor);
        chk({tag, " zero"}, bus8.zero, e_zero);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, bus8.done, 0);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        bit got = 0;
        logic [15:0] e_diff;
        e_diff = a - b;
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.start = 1'b1;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.a = b; bus16.b = a;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (bus16.done) got = 1;
        end
        chk("w16 latency", n, 17);
        chk("w16 diff", bus16.diff, e_diff);
        chk("w16 borrow", bus16.borrow, a < b);
        chk("w16 zero", bus16.zero, a == b);
        @(negedge clk);
        chk("w16 done_one_cycle", bus16.done, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        logic [7:0]  ra, rb, rd;
        logic [15:0] wa, wb;

        vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1, 1'b0};
        vecs[2] = '{8'hA7,  8'hA7,  8'h00,  1'b0, 1'b1};
        vecs[3] = '{8'h00,  8'hFF,  8'h01,  1'b1, 1'b0};
        vecs[4] = '{8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0};
        vecs[5] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b0};
        vecs[6] = '{8'h00,  8'h01,  8'hFF,  1'b1, 1'b0};
        vecs[7] = '{8'h01,  8'h00,  8'h01,  1'b0, 1'b0};

        reset = 1'b1;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", bus8.busy, 0);
        chk("rst done", bus8.done, 0);
        chk("rst diff", bus8.diff, 0);
        chk("rst borrow", bus8.borrow, 0);
        chk("rst zero", bus8.zero, 0);
        chk("rst16 busy", bus16.busy, 0);
        chk("rst16 diff", bus16.diff, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            op8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, vecs[i].zero, $sformatf("vec%0d", i));

        // Reset mid-SHIFT discards the operation and clears previous outputs.
        @(negedge clk);
        bus8.a = 8'h55; bus8.b = 8'h11; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst busy", bus8.busy, 0);
        chk("midrst done", bus8.done, 0);
        chk("midrst diff", bus8.diff, 0);
        chk("midrst borrow", bus8.borrow, 0);
        chk("midrst zero", bus8.zero, 0);
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus8.done) dones++;
        end
        chk("midrst no_done", dones, 0);

        // Reset coincident with start.
        bus8.a = 8'd9; bus8.b = 8'd2; bus8.start = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("rst_vs_start busy", bus8.busy, 0);
        reset = 1'b0; bus8.start = 1'b0;

        // Start held high: captured operands, re-accept the cycle after DONE.
        @(negedge clk);
        bus8.a = 8'd100; bus8.b = 8'd37; bus8.start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (n == 2) begin bus8.a = 8'hFF; bus8.b = 8'h01; end
            if (n == 8) begin bus8.a = 8'd5;  bus8.b = 8'd9;  end
            if (n == 9) begin
                chk("held done1", bus8.done, 1);
                chk("held diff1", bus8.diff, 63);
                chk("held borrow1", bus8.borrow, 0);
            end
            if (n == 10) begin
                chk("held idle busy", bus8.busy, 0);
                chk("held idle done", bus8.done, 0);
            end
            if (n == 11) begin
                chk("held reaccept busy", bus8.busy, 1);
                bus8.start = 1'b0;
            end
            if (n == 19) begin
                chk("held done2", bus8.done, 1);
                chk("held diff2", bus8.diff, 8'hFC);
                chk("held borrow2", bus8.borrow, 1);
                chk("held zero2", bus8.zero, 0);
            end
        end

        // Start pulses while busy are ignored.
        @(negedge clk);
        bus8.a = 8'd20; bus8.b = 8'd30; bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            bus8.start = (n <= 6) && (n % 2 == 0);
            if (bus8.done) dones++;
        end
        chk("pulses done_count", dones, 1);
        chk("pulses diff", bus8.diff, 8'hF6);
        chk("pulses borrow", bus8.borrow, 1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 50 == 0) ? ra : 8'($urandom_range(0, 255));
            rd = ra - rb;
            op8(ra, rb, rd, ra < rb, ra == rb, "rand8");
        end
        for (int i = 0; i < 1000; i++) begin
            wa = 16'($urandom_range(0, 65535));
            wb = (i % 50 == 0) ? wa : 16'($urandom_range(0, 65535));
            op16(wa, wb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
